// File: rtl/punc_run_ctrl.sv
// punc_run_ctrl: run/halt/single-step controller with PC breakpoints for the PUnC core.
// Latency: commands and retire events take effect at the next posedge; core_en is registered.
// Backpressure: cmd_ready drops for one cycle after every accepted command, otherwise high.
// Build option: define PUNC_RUN_CYCLE_CNT_EN to enable the 32-bit enabled-cycle counter.
module punc_run_ctrl #(
   parameter int ADDR_W = 16,
   parameter int NUM_BP = 4,
   parameter int IDX_W  = 2,
   parameter int STEP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [IDX_W-1:0]  cmd_idx,
   input  logic [ADDR_W-1:0] cmd_data,
   input  logic              retire,
   input  logic [ADDR_W-1:0] next_pc,
   output logic              core_en,
   output logic              halted,
   output logic [1:0]        halt_reason,
   output logic [IDX_W-1:0]  bp_hit_idx,
   output logic [STEP_W-1:0] steps_left,
   output logic [31:0]       cycle_count
);

   localparam logic [2:0] OP_NOP     = 3'd0;
   localparam logic [2:0] OP_RUN     = 3'd1;
   localparam logic [2:0] OP_HALT    = 3'd2;
   localparam logic [2:0] OP_STEP    = 3'd3;
   localparam logic [2:0] OP_SET_BP  = 3'd4;
   localparam logic [2:0] OP_CLR_BP  = 3'd5;
   localparam logic [2:0] OP_CLR_ALL = 3'd6;

   localparam logic [1:0] RSN_RESET = 2'd0;
   localparam logic [1:0] RSN_HOST  = 2'd1;
   localparam logic [1:0] RSN_BP    = 2'd2;
   localparam logic [1:0] RSN_STEP  = 2'd3;

   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_RUN  = 2'd1,
      ST_STEP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                core_en_q, core_en_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                pend_halt_q, pend_halt_d;
   logic [1:0]          halt_reason_q, halt_reason_d;
   logic [IDX_W-1:0]    bp_hit_idx_q, bp_hit_idx_d;
   logic [STEP_W-1:0]   steps_left_q, steps_left_d;
   logic [NUM_BP-1:0]   bp_en_q, bp_en_d;
   logic [ADDR_W-1:0]   bp_addr_q [NUM_BP];
   logic [ADDR_W-1:0]   bp_addr_d [NUM_BP];

   logic                cmd_acc;
   logic                idx_ok;
   logic [STEP_W-1:0]   step_req;
   logic                bp_match;
   logic [IDX_W-1:0]    bp_match_idx;

   assign cmd_acc  = cmd_valid & cmd_ready_q;
   assign idx_ok   = (32'(cmd_idx) < 32'(NUM_BP));
   assign step_req = STEP_W'(cmd_data);

   // Compare next_pc against the registered breakpoint table; lowest enabled index wins.
   // A breakpoint written this cycle is still in bp_*_d, so it cannot match this retire.
   always_comb begin
      bp_match     = 1'b0;
      bp_match_idx = '0;
      for (int i = NUM_BP - 1; i >= 0; i--) begin
         if (bp_en_q[i] && (bp_addr_q[i] == next_pc)) begin
            bp_match     = 1'b1;
            bp_match_idx = IDX_W'(i);
         end
      end
   end

   // Breakpoint table updates; legal in any controller state.
   always_comb begin
      bp_en_d   = bp_en_q;
      bp_addr_d = bp_addr_q;
      if (cmd_acc) begin
         for (int i = 0; i < NUM_BP; i++) begin
            if (cmd_op == OP_CLR_ALL) begin
               bp_en_d[i] = 1'b0;
            end else if (idx_ok && (cmd_idx == IDX_W'(i))) begin
               if (cmd_op == OP_SET_BP) begin
                  bp_en_d[i]   = 1'b1;
                  bp_addr_d[i] = next_pc_or_data(cmd_data);
               end else if (cmd_op == OP_CLR_BP) begin
                  bp_en_d[i] = 1'b0;
               end
            end
         end
      end
   end

   function automatic logic [ADDR_W-1:0] next_pc_or_data(input logic [ADDR_W-1:0] d);
      return d;
   endfunction

   // Next-state logic: host commands, instruction-boundary halts and step accounting.
   always_comb begin
      state_d       = state_q;
      pend_halt_d   = pend_halt_q;
      halt_reason_d = halt_reason_q;
      bp_hit_idx_d  = bp_hit_idx_q;
      steps_left_d  = steps_left_q;
      cmd_ready_d   = ~cmd_acc;

      case (state_q)
         ST_HALT: begin
            // Retire in HALT means a core fault; nothing to act on here.
            if (cmd_acc && (cmd_op == OP_RUN)) begin
               state_d = ST_RUN;
            end else if (cmd_acc && (cmd_op == OP_STEP)) begin
               state_d      = ST_STEP;
               steps_left_d = (step_req == '0) ? STEP_W'(1) : step_req;
            end
         end
         ST_RUN, ST_STEP: begin
            // Host halt is only remembered here; it is honoured at a retire.
            if (cmd_acc && (cmd_op == OP_HALT)) begin
               pend_halt_d = 1'b1;
            end
            if (retire) begin
               if ((state_q == ST_STEP) && (steps_left_q != '0)) begin
                  steps_left_d = steps_left_q - STEP_W'(1);
               end
               if (bp_match) begin
                  state_d       = ST_HALT;
                  halt_reason_d = RSN_BP;
                  bp_hit_idx_d  = bp_match_idx;
               end else if (pend_halt_q) begin
                  state_d       = ST_HALT;
                  halt_reason_d = RSN_HOST;
               end else if ((state_q == ST_STEP) && (steps_left_q <= STEP_W'(1))) begin
                  state_d       = ST_HALT;
                  halt_reason_d = RSN_STEP;
               end
               if (state_d == ST_HALT) begin
                  pend_halt_d = 1'b0;
               end
            end
         end
         default: begin
            state_d     = ST_HALT;
            pend_halt_d = 1'b0;
         end
      endcase

      core_en_d = (state_d != ST_HALT);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_HALT;
         core_en_q     <= 1'b0;
         cmd_ready_q   <= 1'b1;
         pend_halt_q   <= 1'b0;
         halt_reason_q <= RSN_RESET;
         bp_hit_idx_q  <= '0;
         steps_left_q  <= '0;
         bp_en_q       <= '0;
         for (int i = 0; i < NUM_BP; i++) begin
            bp_addr_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         core_en_q     <= core_en_d;
         cmd_ready_q   <= cmd_ready_d;
         pend_halt_q   <= pend_halt_d;
         halt_reason_q <= halt_reason_d;
         bp_hit_idx_q  <= bp_hit_idx_d;
         steps_left_q  <= steps_left_d;
         bp_en_q       <= bp_en_d;
         for (int i = 0; i < NUM_BP; i++) begin
            bp_addr_q[i] <= bp_addr_d[i];
         end
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      cmd_ready   = cmd_ready_q;
      core_en     = core_en_q;
      halted      = (state_q == ST_HALT);
      halt_reason = halt_reason_q;
      bp_hit_idx  = bp_hit_idx_q;
      steps_left  = steps_left_q;
   end

`ifdef PUNC_RUN_CYCLE_CNT_EN
   logic [31:0] cycle_cnt_q, cycle_cnt_d;

   // Count cycles in which the core was enabled; CLR_ALL also clears it.
   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      if (cmd_acc && (cmd_op == OP_CLR_ALL)) begin
         cycle_cnt_d = '0;
      end else if (core_en_q) begin
         cycle_cnt_d = cycle_cnt_q + 32'd1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   assign cycle_count = cycle_cnt_q;
`else
   assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_punc_run_ctrl.sv
// tb_punc_run_ctrl: directed bench for punc_run_ctrl with NUM_BP=3.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected values are hand-derived constants for each step of the sequence.
module tb_punc_run_ctrl;

   localparam int ADDR_W = 16;
   localparam int NUM_BP = 3;
   localparam int IDX_W  = 2;
   localparam int STEP_W = 16;

   localparam logic [2:0] OP_RUN     = 3'd1;
   localparam logic [2:0] OP_HALT    = 3'd2;
   localparam logic [2:0] OP_STEP    = 3'd3;
   localparam logic [2:0] OP_SET_BP  = 3'd4;
   localparam logic [2:0] OP_CLR_ALL = 3'd6;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [2:0]        cmd_op = 3'd0;
   logic [IDX_W-1:0]  cmd_idx = '0;
   logic [ADDR_W-1:0] cmd_data = '0;
   logic              retire = 1'b0;
   logic [ADDR_W-1:0] next_pc = '0;
   logic              core_en;
   logic              halted;
   logic [1:0]        halt_reason;
   logic [IDX_W-1:0]  bp_hit_idx;
   logic [STEP_W-1:0] steps_left;
   logic [31:0]       cycle_count;

   int n_chk  = 0;
   int n_fail = 0;

   punc_run_ctrl #(
      .ADDR_W(ADDR_W),
      .NUM_BP(NUM_BP),
      .IDX_W (IDX_W),
      .STEP_W(STEP_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_idx    (cmd_idx),
      .cmd_data   (cmd_data),
      .retire     (retire),
      .next_pc    (next_pc),
      .core_en    (core_en),
      .halted     (halted),
      .halt_reason(halt_reason),
      .bp_hit_idx (bp_hit_idx),
      .steps_left (steps_left),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one command for exactly one cycle once cmd_ready is high.
   task automatic send_cmd(input logic [2:0] op, input logic [IDX_W-1:0] idx,
                           input logic [ADDR_W-1:0] data);
      int waited = 0;
      while (!cmd_ready && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      chk("cmd_ready_before_send", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_idx   = idx;
      cmd_data  = data;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_idx   = '0;
      cmd_data  = '0;
   endtask

   // One-cycle retire pulse with the given next PC.
   task automatic retire_pulse(input logic [ADDR_W-1:0] pc);
      retire  = 1'b1;
      next_pc = pc;
      @(negedge clk);
      retire  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Reset held two cycles.
      repeat (2) @(negedge clk);
      chk("rst_halted", {31'd0, halted}, 32'd1);
      chk("rst_core_en", {31'd0, core_en}, 32'd0);
      chk("rst_reason", {30'd0, halt_reason}, 32'd0);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("rst_steps_left", {16'd0, steps_left}, 32'd0);
      chk("rst_bp_idx", {30'd0, bp_hit_idx}, 32'd0);
      chk("rst_cycle_count", cycle_count, 32'd0);
      rst = 1'b0;

      // Breakpoint halt at 0x3005 on index 1.
      send_cmd(OP_SET_BP, 2'd1, 16'h3005);
      chk("setbp_turnaround", {31'd0, cmd_ready}, 32'd0);
      send_cmd(OP_RUN, 2'd0, 16'h0);
      chk("run_core_en", {31'd0, core_en}, 32'd1);
      chk("run_halted", {31'd0, halted}, 32'd0);
      for (int k = 1; k <= 4; k++) begin
         retire_pulse(16'h3000 + 16'(k));
         chk("run_pre_bp_core_en", {31'd0, core_en}, 32'd1);
      end
      retire_pulse(16'h3005);
      chk("bp_core_en", {31'd0, core_en}, 32'd0);
      chk("bp_halted", {31'd0, halted}, 32'd1);
      chk("bp_reason", {30'd0, halt_reason}, 32'd2);
      chk("bp_idx", {30'd0, bp_hit_idx}, 32'd1);

      // Resume: executes past the breakpoint without re-triggering.
      send_cmd(OP_RUN, 2'd0, 16'h0);
      chk("resume_core_en", {31'd0, core_en}, 32'd1);
      retire_pulse(16'h3006);
      chk("resume_no_retrigger", {31'd0, core_en}, 32'd1);

      // Host halt mid-instruction: waits for the next retire.
      send_cmd(OP_HALT, 2'd0, 16'h0);
      chk("halt_turnaround_low", {31'd0, cmd_ready}, 32'd0);
      chk("halt_pending_core_en", {31'd0, core_en}, 32'd1);
      @(negedge clk);
      chk("halt_turnaround_high", {31'd0, cmd_ready}, 32'd1);
      chk("halt_pending_core_en2", {31'd0, core_en}, 32'd1);
      retire_pulse(16'h3007);
      chk("host_halt_core_en", {31'd0, core_en}, 32'd0);
      chk("host_halt_reason", {30'd0, halt_reason}, 32'd1);

      // Counted step of 3, retires 5 cycles apart.
      send_cmd(OP_CLR_ALL, 2'd0, 16'h0);
      send_cmd(OP_STEP, 2'd0, 16'd3);
      chk("step3_steps", {16'd0, steps_left}, 32'd3);
      chk("step3_core_en", {31'd0, core_en}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         repeat (4) @(negedge clk);
         retire_pulse(16'h4000 + 16'(k));
         chk("step3_steps_left", {16'd0, steps_left}, 32'(2 - k));
         chk("step3_halted", {31'd0, halted}, (k == 2) ? 32'd1 : 32'd0);
      end
      chk("step3_reason", {30'd0, halt_reason}, 32'd3);

      // STEP with count 0 runs exactly one instruction.
      send_cmd(OP_STEP, 2'd0, 16'd0);
      chk("step0_steps", {16'd0, steps_left}, 32'd1);
      chk("step0_core_en", {31'd0, core_en}, 32'd1);
      retire_pulse(16'h4010);
      chk("step0_halted", {31'd0, halted}, 32'd1);
      chk("step0_reason", {30'd0, halt_reason}, 32'd3);

      // Priority: breakpoint beats pending host halt and step completion.
      send_cmd(OP_SET_BP, 2'd2, 16'h5002);
      send_cmd(OP_SET_BP, 2'd3, 16'h5001);
      send_cmd(OP_STEP, 2'd0, 16'd2);
      retire_pulse(16'h5001);
      chk("prio_oob_bp_ignored", {31'd0, halted}, 32'd0);
      chk("prio_steps_mid", {16'd0, steps_left}, 32'd1);
      send_cmd(OP_HALT, 2'd0, 16'h0);
      retire_pulse(16'h5002);
      chk("prio_halted", {31'd0, halted}, 32'd1);
      chk("prio_reason", {30'd0, halt_reason}, 32'd2);
      chk("prio_bp_idx", {30'd0, bp_hit_idx}, 32'd2);
      chk("prio_steps_end", {16'd0, steps_left}, 32'd0);

      // Pending halt must be consumed by that halt.
      send_cmd(OP_RUN, 2'd0, 16'h0);
      retire_pulse(16'h5003);
      chk("pend_cleared_core_en", {31'd0, core_en}, 32'd1);

      // Lowest matching index wins.
      send_cmd(OP_SET_BP, 2'd2, 16'h6000);
      send_cmd(OP_SET_BP, 2'd0, 16'h6000);
      @(negedge clk);
      retire_pulse(16'h6000);
      chk("lowest_halted", {31'd0, halted}, 32'd1);
      chk("lowest_idx", {30'd0, bp_hit_idx}, 32'd0);

      // Retire in HALT is ignored.
      retire_pulse(16'h7000);
      chk("halt_retire_ignored", {31'd0, halted}, 32'd1);
      chk("halt_retire_reason", {30'd0, halt_reason}, 32'd2);

      // Reset again, then count 10 enabled cycles.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst2_reason", {30'd0, halt_reason}, 32'd0);
      chk("rst2_cycle_count", cycle_count, 32'd0);
      send_cmd(OP_RUN, 2'd0, 16'h0);
      chk("cnt_start", cycle_count, 32'd0);
      repeat (10) @(negedge clk);
`ifdef PUNC_RUN_CYCLE_CNT_EN
      chk("cnt_ten", cycle_count, 32'd10);
`else
      chk("cnt_disabled", cycle_count, 32'd0);
`endif
      chk("cnt_core_en", {31'd0, core_en}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_run_core_en", {31'd0, core_en}, 32'd0);
      chk("rst_mid_run_count", cycle_count, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
